// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
//   Direct-mapped, write-back, write-allocate L1 data cache sitting between
//   the MEM stage and a word-serial main memory. Hits are served in the
//   access cycle. A miss stalls the pipeline (via `miss`) while the FSM
//   writes back a dirty victim line and refills the line word 0 first.
//
// Ports
//   clk, rst_n           core clock, asynchronous active-low reset
//   rd_req, wr_req       MEM-stage load / store request (both = store)
//   addr, wr_data        byte address (addr[1:0] ignored), store data
//   rd_data              load data, valid when rd_req=1 and miss=0, else 0
//   miss                 combinational stall request to the hazard unit
//   mem_req, mem_we      memory beat request (held until ack), 1 = write
//   mem_addr, mem_wdata  word-aligned beat address, writeback data
//   mem_rdata, mem_ack   fill data, one-cycle beat acknowledge
//   miss_count           misses taken since reset (wraps)
// ---------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] miss_count
);

    localparam int TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int WORDS   = 1 << LINE_ADDR_LEN;
    localparam int SETS    = 1 << SET_ADDR_LEN;
    localparam logic [LINE_ADDR_LEN-1:0] LAST_BEAT = LINE_ADDR_LEN'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL
    } state_t;

    state_t state, state_nxt;

    // Storage
    logic [SETS-1:0]    valid;
    logic [SETS-1:0]    dirty;
    logic [TAG_LEN-1:0] tag_mem  [SETS];
    logic [31:0]        data_mem [SETS][WORDS];

    // Miss context, latched when the miss is taken
    logic [SET_ADDR_LEN-1:0]  lat_set;
    logic [TAG_LEN-1:0]       vic_tag;
    logic [TAG_LEN-1:0]       fill_tag;
    logic [LINE_ADDR_LEN-1:0] beat;

    // Address decode
    logic [TAG_LEN-1:0]       req_tag;
    logic [SET_ADDR_LEN-1:0]  req_set;
    logic [LINE_ADDR_LEN-1:0] req_word;
    logic                     req;
    logic                     tag_hit;
    logic                     hit;
    logic                     take_miss;
    logic                     last_ack;
    logic                     unused_addr_bits;

    assign req_tag  = addr[31 -: TAG_LEN];
    assign req_set  = addr[SET_ADDR_LEN+LINE_ADDR_LEN+1 : LINE_ADDR_LEN+2];
    assign req_word = addr[LINE_ADDR_LEN+1 : 2];
    assign unused_addr_bits = ^addr[1:0];

    assign req       = rd_req | wr_req;
    assign tag_hit   = valid[req_set] && (tag_mem[req_set] == req_tag);
    assign hit       = (state == IDLE) && req && tag_hit;
    assign take_miss = (state == IDLE) && req && !tag_hit;
    assign last_ack  = mem_ack && (beat == LAST_BEAT);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default at the top of the block
    // so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take_miss) begin
                    state_nxt = (valid[req_set] && dirty[req_set]) ? WB : FILL;
                end
            end
            WB:      if (last_ack) state_nxt = FILL;
            FILL:    if (last_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        miss      = 1'b0;
        rd_data   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                miss = take_miss;
                if (hit && rd_req) begin
                    rd_data = data_mem[req_set][req_word];
                end
            end
            WB: begin
                miss      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vic_tag, lat_set, beat, 2'b00};
                mem_wdata = data_mem[lat_set][beat];
            end
            FILL: begin
                miss     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {fill_tag, lat_set, beat, 2'b00};
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control state: valid/dirty bits, miss context, beat counter, counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= '0;
            dirty      <= '0;
            lat_set    <= '0;
            vic_tag    <= '0;
            fill_tag   <= '0;
            beat       <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_miss) begin
                        miss_count <= miss_count + 32'd1;
                        lat_set    <= req_set;
                        vic_tag    <= tag_mem[req_set];
                        fill_tag   <= req_tag;
                        beat       <= '0;
                    end else if (hit && wr_req) begin
                        dirty[req_set] <= 1'b1;
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        beat <= beat + 1'b1;  // wraps to 0 for the fill
                    end
                    if (last_ack) begin
                        dirty[lat_set] <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        beat <= beat + 1'b1;
                    end
                    if (last_ack) begin
                        valid[lat_set] <= 1'b1;
                        dirty[lat_set] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Tag and data arrays
    // -----------------------------------------------------------------------
    // NOTE: the arrays carry no reset; the valid bits alone decide whether
    // their contents mean anything, so clearing them would only cost logic.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) begin
            data_mem[lat_set][beat] <= mem_rdata;
            if (beat == LAST_BEAT) begin
                tag_mem[lat_set] <= fill_tag;
            end
        end else if (hit && wr_req) begin
            data_mem[req_set][req_word] <= wr_data;
        end
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and word-serial main memory.
- Serves hits in the access cycle.
- On a miss it raises `miss`, which drives the hazard unit's DCacheMiss input; this stalls the whole pipeline while the FSM writes back the dirty victim line and refills the line.
- The access then completes as a hit.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line (N = 2^LINE_ADDR_LEN = 8).
- SET_ADDR_LEN, 4, log2 of number of sets (16).
- TAG_LEN, 30-LINE_ADDR_LEN-SET_ADDR_LEN, tag width. Derived; not to be overridden.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  MEM-stage load request (word).
- wr_req  in  1  MEM-stage store request (word).
- addr  in  32  byte address. addr[1:0] is ignored; word-only access.
- wr_data  in  32  store data.
- rd_data  out  32  load data: valid when rd_req=1 and miss=0, else 0.
- miss  out  1  combinational. 1 while the current request is not yet servable; goes to the hazard unit DCacheMiss input.
- mem_req  out  1  memory beat request; held until mem_ack.
- mem_we  out  1  1 = write beat (writeback), 0 = read beat (fill).
- mem_addr  out  32  word-aligned byte address of the current beat.
- mem_wdata  out  32  writeback data for the current beat.
- mem_rdata  in  32  fill data; valid when mem_ack=1 and mem_we=0.
- mem_ack  in  1  one-cycle beat acknowledge.
- miss_count  out  32  number of misses taken since reset; increments once per IDLE->WB/FILL transition.

Behaviour:
- Address split: tag=addr[31:32-TAG_LEN], set=addr[SET_ADDR_LEN+LINE_ADDR_LEN+1:LINE_ADDR_LEN+2], word=addr[LINE_ADDR_LEN+1:2].
- Storage per set: valid, dirty, tag, N×32 data.
  - Reset clears valid, dirty, miss_count, state and all outputs.
  - The data and tag arrays are not reset.
- Hit: state==IDLE, req active, valid[set], tag match.
  - Load returns the word combinationally, miss=0.
  - Store writes the word and sets dirty at the same edge, miss=0.
- rd_req and wr_req both 1: treated as a store.
- No request: miss=0, no state change.
- FSM states: IDLE, WB, FILL.
- IDLE:
  - Request and no hit: miss=1, miss_count++, and the victim line index is latched.
  - Next state is WB if the victim is valid&dirty, else FILL.
  - Requests arriving while not in IDLE are ignored (pipeline is stalled).
- WB:
  - Beats k=0..N-1: mem_req=1, mem_we=1, mem_addr={victim tag, set, k, 2'b00}, mem_wdata=line[k].
  - The beat counter advances on mem_ack. On the last ack: dirty cleared, next state FILL.
- FILL:
  - Beats k=0..N-1: mem_req=1, mem_we=0, mem_addr={req tag, set, k, 2'b00}. mem_rdata is written to line[k] on mem_ack.
  - On the last ack: tag written, valid=1, dirty=0, next state IDLE.
- miss=1 in every WB/FILL cycle. The stalled request then hits in IDLE and completes; a store hit sets dirty then.
- Fill order is always word 0 first; there is no critical-word-first and no early restart.
- mem_req/mem_we/mem_addr/mem_wdata are stable from assertion through the ack cycle.
  - mem_req is deasserted for zero cycles between beats: the next beat is presented the cycle after the ack.
  - mem_req=0 in IDLE.
- Latency with zero-wait memory (ack in the first request cycle):
  - clean miss: miss high N+1 cycles.
  - dirty miss: miss high 2N+1 cycles.
  - Each extra wait cycle per beat adds 1.
- The address is expected stable during miss (pipeline stalled). If addr changes mid-miss, the fill completes for the latched set/tag and the new address is evaluated in IDLE.
- Reset asserted mid-WB/FILL: immediate return to IDLE with mem_req=0. All lines are invalidated; the partial line is discarded and no dirty data is preserved.
- miss_count wraps at 2^32.

Test Plan:
- Cold load: reset, rd_req addr=0x0000_0040, memory word i = 0x1000+i, zero-wait ack.
  - Required: miss=1 for 9 cycles, 8 read beats addrs 0x40..0x5C, then rd_data=0x1000+16 with miss=0, miss_count=1.
- Load hits: following the cold load, loads 0x44 and 0x5C.
  - Required: miss=0, rd_data=0x1011 and 0x1017, mem_req=0.
- Dirty eviction:
  - Store 0xDEADBEEF to 0x48 (hit, miss=0).
  - Load 0x0000_0448 (same set, new tag).
  - Required: 8 write beats 0x40..0x5C with beat 2 data 0xDEADBEEF, then 8 read beats 0x440..0x45C; miss high 17 cycles, miss_count=2.
- Slow memory: ack 3 cycles after each mem_req, clean miss.
  - Required: miss high 1+8×3=25 cycles; beat address and mem_we held stable until ack.
- Reset mid-fill: assert rst_n=0 during FILL beat 4.
  - Required: mem_req=0 and miss_count=0 immediately. After release, a load to the same address misses again and refills fully.
- Store miss (write-allocate): store 0x12345678 to an empty set.
  - Required: fill of the line, then the store hits. A subsequent load returns 0x12345678 and the line's dirty bit is set (an eviction triggers a writeback).
